// File: rtl/sync_debounce_pkg.sv
// Shared constants and helpers for the sync_debounce input conditioner.
// Optional debounce filter is enabled with the SYNC_DEBOUNCE_EN macro.
package sync_pkg;

    localparam int SYNC_STAGES_DEFAULT = 2;
    localparam int DEBOUNCE_DEFAULT    = 1000;

    // Width of a counter that must hold values 0..n.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/sync_debounce_channel.sv
// One conditioned channel: optional stability filter (SYNC_DEBOUNCE_EN)
// followed by registered single-cycle rise/fall edge pulses.
module debounce_channel
    import sync_pkg::*;
`ifdef SYNC_DEBOUNCE_EN
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
)
`endif
(
    input  logic clock,
    input  logic reset_n,
    input  logic sync,
    output logic level,
    output logic rise,
    output logic fall
);

    logic level_q;
    logic level_d;
    logic rise_q;
    logic fall_q;

`ifdef SYNC_DEBOUNCE_EN
    localparam int                CNT_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Count consecutive disagreeing cycles; adopt the new value at the terminal count.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (sync != level_q) begin
            if (cnt_q == CNT_TERM) begin
                level_d = sync;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Stability counter register; a reset abandons any run in progress.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    // Without the filter the level simply follows the synchronised input.
    assign level_d = sync;
`endif

    // Level register plus edge pulses derived from next vs. current level.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            level_q <= level_d;
            rise_q  <= level_d & ~level_q;
            fall_q  <= ~level_d & level_q;
        end
    end

    assign level = level_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule

// File: rtl/sync_debounce.sv
// Multi-channel input conditioner: STAGES-deep synchroniser per channel,
// then a debounce_channel per channel. Macro SYNC_DEBOUNCE_EN enables the
// DEBOUNCE_CYCLES stability filter; otherwise level follows the synchroniser.
module sync_debounce
    import sync_pkg::*;
#(
    parameter int WIDTH           = 1,
    parameter int STAGES          = SYNC_STAGES_DEFAULT,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
)
(
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] asyncinput,
    output logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    if (WIDTH < 1) begin : g_bad_width
        $error("sync_debounce: WIDTH must be >= 1");
    end
    if (STAGES < 2) begin : g_bad_stages
        $error("sync_debounce: STAGES must be >= 2");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("sync_debounce: DEBOUNCE_CYCLES must be >= 1");
    end

    // Bit 0 of each channel is the first capture flop, bit STAGES-1 is sync.
    logic [WIDTH-1:0][STAGES-1:0] chain_q;

    // Plain flop-to-flop shift chains, no logic between stages.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            chain_q <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                chain_q[i] <= {chain_q[i][STAGES-2:0], asyncinput[i]};
            end
        end
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_ch
`ifdef SYNC_DEBOUNCE_EN
        debounce_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_ch (
            .clock  (clock),
            .reset_n(reset_n),
            .sync   (chain_q[g][STAGES-1]),
            .level  (level[g]),
            .rise   (rise[g]),
            .fall   (fall[g])
        );
`else
        debounce_channel u_ch (
            .clock  (clock),
            .reset_n(reset_n),
            .sync   (chain_q[g][STAGES-1]),
            .level  (level[g]),
            .rise   (rise[g]),
            .fall   (fall[g])
        );
`endif
    end

endmodule

// File: tb/tb_sync_debounce.sv
// Directed bench for sync_debounce (WIDTH=4, STAGES=2, DEBOUNCE_CYCLES=4).
// Works in both builds; latency is 5 edges with SYNC_DEBOUNCE_EN, 2 without.
module tb_sync_debounce;

`ifdef SYNC_DEBOUNCE_EN
    localparam int LAT = 5;
`else
    localparam int LAT = 2;
`endif

    logic       clock = 1'b0;
    logic       reset_n;
    logic [3:0] asyncinput;
    logic [3:0] level;
    logic [3:0] rise;
    logic [3:0] fall;

    int vectors     = 0;
    int miscompares = 0;

    sync_debounce #(
        .WIDTH          (4),
        .STAGES         (2),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .asyncinput(asyncinput),
        .level     (level),
        .rise      (rise),
        .fall      (fall)
    );

    always #5 clock = ~clock;

    // Advance past the next rising edge and settle.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk3(input string tag, input logic [3:0] l, input logic [3:0] r,
                        input logic [3:0] f);
        chk({tag, ".level"}, level, l);
        chk({tag, ".rise"},  rise,  r);
        chk({tag, ".fall"},  fall,  f);
    endtask

    initial begin
        // Reset held with all inputs high
        reset_n    = 1'b1;
        asyncinput = 4'hF;
        #1 reset_n = 1'b0;
        #2;
        chk3("rst_hold0", 4'h0, 4'h0, 4'h0);
        step();
        step();
        chk3("rst_hold1", 4'h0, 4'h0, 4'h0);
        reset_n = 1'b1;
        for (int k = 1; k <= LAT + 2; k++) begin
            step();
            chk3("rst_release", (k >= LAT + 1) ? 4'hF : 4'h0,
                 (k == LAT + 1) ? 4'hF : 4'h0, 4'h0);
        end

        // All channels fall together
        asyncinput = 4'h0;
        for (int k = 1; k <= LAT + 3; k++) begin
            step();
            chk3("all_fall", (k >= LAT + 1) ? 4'h0 : 4'hF, 4'h0,
                 (k == LAT + 1) ? 4'hF : 4'h0);
        end

`ifdef SYNC_DEBOUNCE_EN
        // Three-cycle glitch on channel 0 must be rejected
        asyncinput = 4'h1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk3("glitch_in", 4'h0, 4'h0, 4'h0);
        end
        asyncinput = 4'h0;
        for (int k = 0; k < 8; k++) begin
            step();
            chk3("glitch_after", 4'h0, 4'h0, 4'h0);
        end
`else
        // One-cycle glitch on channel 0 passes as a one-cycle level pulse
        asyncinput = 4'h1;
        step();
        asyncinput = 4'h0;
        step();
        chk3("glitch_e1", 4'h0, 4'h0, 4'h0);
        step();
        chk3("glitch_e2", 4'h1, 4'h1, 4'h0);
        step();
        chk3("glitch_e3", 4'h0, 4'h0, 4'h1);
        step();
        chk3("glitch_e4", 4'h0, 4'h0, 4'h0);
`endif

        // Channel 1 held high for 10 cycles then released
        asyncinput = 4'h2;
        for (int k = 1; k <= 10; k++) begin
            step();
            chk3("ch1_rise", (k >= LAT + 1) ? 4'h2 : 4'h0,
                 (k == LAT + 1) ? 4'h2 : 4'h0, 4'h0);
        end
        asyncinput = 4'h0;
        for (int k = 1; k <= 10; k++) begin
            step();
            chk3("ch1_fall", (k >= LAT + 1) ? 4'h0 : 4'h2, 4'h0,
                 (k == LAT + 1) ? 4'h2 : 4'h0);
        end

        // Channels 0 and 2 rise in the same cycle
        asyncinput = 4'h5;
        for (int k = 1; k <= 8; k++) begin
            step();
            chk3("simul_rise", (k >= LAT + 1) ? 4'h5 : 4'h0,
                 (k == LAT + 1) ? 4'h5 : 4'h0, 4'h0);
        end

        // Channels 1 and 3 start counting, then reset mid-run
        asyncinput = 4'hF;
        for (int k = 0; k < 4; k++) begin
            step();
        end
        reset_n = 1'b0;
        #2;
        chk3("midrst_async", 4'h0, 4'h0, 4'h0);
        step();
        chk3("midrst_hold", 4'h0, 4'h0, 4'h0);
        reset_n = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            chk3("midrst_restart", (k >= LAT + 1) ? 4'hF : 4'h0,
                 (k == LAT + 1) ? 4'hF : 4'h0, 4'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sync_debounce.md
# sync_debounce

Parametrised multi-channel input conditioner that brings WIDTH asynchronous signals (buttons, switches, external strobes) into the `clock` domain through a configurable-depth flop chain. It optionally debounces each channel and emits single-cycle rise/fall pulses. It sits directly behind the board I/O pins, ahead of any control FSM that consumes them. It replaces the fixed two-flop, single-bit synchroniser.

## Interface
- WIDTH, default 1: number of independent channels (≥1).
- STAGES, default 2: synchroniser flops per channel (≥2).
- DEBOUNCE_CYCLES, default 1000: consecutive stable cycles required before `level` changes (≥1). Used only with `SYNC_DEBOUNCE_EN`.
- clock  input  1  sole clock; all state updates on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- asyncinput  input  WIDTH  raw asynchronous channel inputs.
- level  output  WIDTH  conditioned (synchronised, optionally debounced) channel state.
- rise  output  WIDTH  one-cycle pulse, high in the first cycle `level[i]` is 1 after being 0.
- fall  output  WIDTH  one-cycle pulse, high in the first cycle `level[i]` is 0 after being 1.

## Operation
- Per channel, `asyncinput[i]` enters a STAGES-deep shift chain. The last stage is `sync[i]`. No logic sits between chain flops.
- Debounce, with macro defined:
  - Each channel keeps a counter of width `$clog2(DEBOUNCE_CYCLES+1)` and a `level` register.
  - If `sync == level`, the counter is cleared to 0.
  - If `sync != level` and `counter < DEBOUNCE_CYCLES-1`, the counter increments.
  - If `sync != level` and `counter == DEBOUNCE_CYCLES-1`, `level <= sync` and the counter is cleared.
  - Any return of `sync` to `level` before the terminal count discards the run. Glitches shorter than DEBOUNCE_CYCLES cycles never reach `level`.
  - The counter never wraps; saturation is impossible by construction.
- Edge detect:
  - `rise[i]` and `fall[i]` are registered. They are computed from the next and current `level` so they assert in the same cycle `level` changes.
  - They are never both high, and never high for two consecutive cycles on the same channel.
- Channels are fully independent. Simultaneous transitions on several channels each produce their own pulses in the same cycle.
- Reset (reset_n low):
  - Immediately, without a clock, clears all chain flops, counters, `level`, `rise` and `fall` to 0.
  - A reset asserted mid-count abandons the run.
  - After release with `asyncinput` held high, `level` rises after the normal latency and `rise` fires once.
- Elaboration `$error` if WIDTH<1, STAGES<2 or DEBOUNCE_CYCLES<1.

## Timing
- Input change set up before edge e0 appears on `sync` at edge e0+STAGES-1.
- With macro: `level`, `rise` and `fall` update at edge e0+STAGES-1+DEBOUNCE_CYCLES.
- Without macro: `level`, `rise` and `fall` update at edge e0+STAGES. This is identical to DEBOUNCE_CYCLES=1.
- Pulse width is exactly one clock.
- Reset values: `level`=0, `rise`=0, `fall`=0.

## Configuration
- `SYNC_DEBOUNCE_EN` defined: per-channel counters are instantiated and the DEBOUNCE_CYCLES filter applies.
- Not defined:
  - No counters are instantiated and DEBOUNCE_CYCLES is ignored.
  - `level <= sync` every cycle; edge outputs are unchanged in behaviour.
  - Port list is identical in both builds.

## Structure
- Package `sync_pkg`:
  - Holds a `cnt_width(n)` function returning `$clog2(n+1)`.
  - Holds the default constants `SYNC_STAGES_DEFAULT=2` and `DEBOUNCE_DEFAULT=1000`.
- Sub-module `debounce_channel`:
  - One instance per channel via generate loop.
  - Ports: clock, reset_n, sync, level, rise, fall.
  - Contains the counter (under macro) and the edge registers.
- The top level contains the synchroniser chains and the generate loop.

## Test plan
All scenarios use WIDTH=4, STAGES=2, DEBOUNCE_CYCLES=4, macro defined unless noted.
- Reset: hold `asyncinput`=4'hF through reset -> all outputs 0 while reset_n low. After release, `level`=4'hF at edge e0+5, and `rise`=4'hF for exactly that one cycle.
- Glitch reject: `level`=0, then pulse `asyncinput[0]` high for 3 cycles -> `level`, `rise` and `fall` stay 0.
- Accept and release: hold `asyncinput[1]` high 10 cycles then low -> `rise[1]` one cycle 5 edges after the rising input, and `fall[1]` one cycle 5 edges after the falling input.
- Simultaneous channels: `asyncinput` 4'h0→4'h5 -> `rise`=4'h5 in a single cycle, with no pulse on channels 1 or 3.
- Mid-count reset: assert reset_n low at counter=2 -> outputs 0 immediately. After release with input still high, the full 5-edge latency restarts.
- Macro undefined: 4'h0→4'h3 -> `level`=4'h3 and `rise`=4'h3 at edge e0+2. A 1-cycle `asyncinput` glitch passes through as a one-cycle `level` pulse.
